// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: EX-side HI/LO op request plus HI/LO register-file read/write ports.
interface hilo_muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;
    logic        busy;
    logic        hi_wen;
    logic [31:0] hi_wdata;
    logic        lo_wen;
    logic [31:0] lo_wdata;
    modport master (
        output op_valid, op, src_a, src_b, flush, hi_rdata, lo_rdata,
        input  busy, hi_wen, hi_wdata, lo_wen, lo_wdata
    );
    modport slave (
        input  op_valid, op, src_a, src_b, flush, hi_rdata, lo_rdata,
        output busy, hi_wen, hi_wdata, lo_wen, lo_wdata
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO with registered write ports.
// Define HILO_MADD_EN to add MADD/MSUB accumulating into {HI,LO}.
module hilo_muldiv_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_ITERS   = 32
) (
    input logic clk,
    input logic reset,
    hilo_muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;
    state_t state, state_nx;
    logic        busy_q, hi_wen_q, lo_wen_q, hi_wen_nx, lo_wen_nx;
    logic [31:0] hi_wd_q, lo_wd_q, hi_wd_nx, lo_wd_nx;
    logic [31:0] a_q, b_q, rem_q, quo_q;
    logic [4:0]  cnt_q;
    logic        sgn_q, bneg_q;
    logic        legal, accept, is_mt, is_div, sgn_in;
    logic [31:0] a_mag, b_mag;
    logic [63:0] ax, bx, prod, mul_res;
    logic [32:0] diff;
    logic [31:0] rem_nx, quo_nx, div_hi, div_lo;

`ifdef HILO_MADD_EN
    logic [63:0] acc_q;
    logic        msub_q;
    assign legal   = 1'b1;
    assign mul_res = msub_q ? acc_q - prod : acc_q + prod;
`else
    assign legal   = ~(bus.op[2] & bus.op[1]);
    assign mul_res = prod;
`endif

    assign accept = bus.op_valid & ~busy_q & ~bus.flush & legal;
    assign is_mt  = bus.op[2] & ~bus.op[1];
    assign is_div = ~bus.op[2] & bus.op[1];
    assign sgn_in = ~bus.op[0] | bus.op[2];
    assign a_mag  = (sgn_in & bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign b_mag  = (sgn_in & bus.src_b[31]) ? -bus.src_b : bus.src_b;

    // low 64 bits of a 64x64 product of sign-extended operands give the signed result
    assign ax   = {{32{sgn_q & a_q[31]}}, a_q};
    assign bx   = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod = ax * bx;

    // one restoring step; the final step feeds write-back directly so WB lands on T+33
    assign diff   = {rem_q, quo_q[31]} - {1'b0, b_q};
    assign rem_nx = diff[32] ? {rem_q[30:0], quo_q[31]} : diff[31:0];
    assign quo_nx = {quo_q[30:0], ~diff[32]};
    assign div_lo = (b_q == '0) ? '1 : (sgn_q & (a_q[31] ^ bneg_q)) ? -quo_nx : quo_nx;
    assign div_hi = (b_q == '0) ? a_q : (sgn_q & a_q[31]) ? -rem_nx : rem_nx;

    always_comb begin
        state_nx  = state;
        hi_wen_nx = 1'b0;
        lo_wen_nx = 1'b0;
        hi_wd_nx  = hi_wd_q;
        lo_wd_nx  = lo_wd_q;
        case (state)
            IDLE: if (accept) begin
                state_nx  = is_mt ? IDLE : is_div ? DIV : MUL;
                hi_wen_nx = is_mt & ~bus.op[0];
                lo_wen_nx = is_mt & bus.op[0];
                hi_wd_nx  = hi_wen_nx ? bus.src_a : hi_wd_q;
                lo_wd_nx  = lo_wen_nx ? bus.src_a : lo_wd_q;
            end
            MUL, DIV: if (bus.flush) begin
                state_nx = IDLE;
            end else if (cnt_q == '0) begin
                state_nx  = WB;
                hi_wen_nx = 1'b1;
                lo_wen_nx = 1'b1;
                hi_wd_nx  = (state == MUL) ? mul_res[63:32] : div_hi;
                lo_wd_nx  = (state == MUL) ? mul_res[31:0] : div_lo;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            hi_wen_q <= 1'b0;
            lo_wen_q <= 1'b0;
            hi_wd_q  <= '0;
            lo_wd_q  <= '0;
        end else begin
            state    <= state_nx;
            busy_q   <= state_nx != IDLE;
            hi_wen_q <= hi_wen_nx;
            lo_wen_q <= lo_wen_nx;
            hi_wd_q  <= hi_wd_nx;
            lo_wd_q  <= lo_wd_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            sgn_q  <= 1'b0;
            bneg_q <= 1'b0;
`ifdef HILO_MADD_EN
            acc_q  <= '0;
            msub_q <= 1'b0;
`endif
        end else if (accept && !is_mt) begin
            a_q    <= bus.src_a;
            b_q    <= is_div ? b_mag : bus.src_b;
            quo_q  <= a_mag;
            rem_q  <= '0;
            cnt_q  <= is_div ? 5'(DIV_ITERS - 1) : 5'(MUL_LATENCY - 1);
            sgn_q  <= sgn_in;
            bneg_q <= sgn_in & bus.src_b[31];
`ifdef HILO_MADD_EN
            acc_q  <= bus.op[2] ? {bus.hi_rdata, bus.lo_rdata} : '0;
            msub_q <= bus.op[2] & bus.op[0];
`endif
        end else if (state == DIV) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - 5'd1;
        end else if (state == MUL) begin
            cnt_q <= cnt_q - 5'd1;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.hi_wen   = hi_wen_q;
    assign bus.lo_wen   = lo_wen_q;
    assign bus.hi_wdata = hi_wd_q;
    assign bus.lo_wdata = lo_wd_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed + randomized bench against an arithmetic HI/LO model.
// Honours HILO_MADD_EN the same way as the design.
module tb_hilo_muldiv_ctrl;
    localparam int LAT = 4;
`ifdef HILO_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    hilo_muldiv_ctrl_if bus();
    hilo_muldiv_ctrl #(.MUL_LATENCY(LAT), .DIV_ITERS(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {HI,LO} after the op, from plain arithmetic on the architectural values
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
        longint sp;
        int sa, sb;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        if (op == 3'd0) return sp;
        if (op == 3'd1) return {32'd0, a} * {32'd0, b};
        if (op == 3'd2 || op == 3'd3) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == 3'd3) return {a % b, a / b};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
        end
        if (op == 3'd4) return {a, lo};
        if (op == 3'd5) return {hi, a};
        if (op == 3'd6) return {hi, lo} + sp;
        return {hi, lo} - sp;
    endfunction

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int lat;
        e = model(op, a, b, hi_m, lo_m);
        lat = (op == 3'd2 || op == 3'd3) ? 32 : LAT;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.hi_rdata = hi_m;
        bus.lo_rdata = lo_m;
        step();
        bus.op_valid = 1'b0;
        if (op >= 3'd6 && !MADD_EN) begin
            check($sformatf("illegal_busy op%0d", op), bus.busy, 0);
            check($sformatf("illegal_hi_wen op%0d", op), bus.hi_wen, 0);
            check($sformatf("illegal_lo_wen op%0d", op), bus.lo_wen, 0);
            return;
        end
        if (op == 3'd4 || op == 3'd5) begin
            check($sformatf("mt_busy op%0d", op), bus.busy, 0);
            check($sformatf("mt_hi_wen op%0d", op), bus.hi_wen, op == 3'd4);
            check($sformatf("mt_lo_wen op%0d", op), bus.lo_wen, op == 3'd5);
            if (op == 3'd4) check("mthi_data", bus.hi_wdata, a);
            else check("mtlo_data", bus.lo_wdata, a);
            {hi_m, lo_m} = e;
            return;
        end
        for (int k = 1; k <= lat + 1; k++) begin
            if (k > 1) step();
            check($sformatf("busy op%0d k%0d", op, k), bus.busy, 1);
            check($sformatf("hi_wen op%0d k%0d", op, k), bus.hi_wen, k == lat + 1);
            check($sformatf("lo_wen op%0d k%0d", op, k), bus.lo_wen, k == lat + 1);
        end
        check($sformatf("hi_wdata op%0d a=%h b=%h", op, a, b), bus.hi_wdata, e[63:32]);
        check($sformatf("lo_wdata op%0d a=%h b=%h", op, a, b), bus.lo_wdata, e[31:0]);
        {hi_m, lo_m} = e;
        step();
        check($sformatf("post_busy op%0d", op), bus.busy, 0);
        check($sformatf("post_wen op%0d", op), {bus.hi_wen, bus.lo_wen}, 0);
    endtask

    initial begin
        logic [2:0] rop;
        logic [31:0] ra, rb;
        bus.op_valid = 1'b0;
        bus.op = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        bus.hi_rdata = '0;
        bus.lo_rdata = '0;
        repeat (3) step();
        check("rst_busy", bus.busy, 0);
        check("rst_hi_wen", bus.hi_wen, 0);
        check("rst_lo_wen", bus.lo_wen, 0);
        check("rst_hi_wdata", bus.hi_wdata, 0);
        check("rst_lo_wdata", bus.lo_wdata, 0);
        @(negedge clk);
        reset = 1'b0;

        run(3'd5, 32'h1234_5678, 32'd0);
        run(3'd4, 32'hCAFE_F00D, 32'd0);
        run(3'd0, 32'hFFFF_FFFD, 32'd5);
        run(3'd1, 32'hFFFF_FFFD, 32'd5);
        run(3'd2, 32'hFFFF_FFF9, 32'd2);
        run(3'd3, 32'd100, 32'd7);
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd2, 32'hFFFF_FFF9, 32'd0);

        // divide by zero with op_valid held through busy; the held MTHI lands after WB
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = 3'd3;
        bus.src_a = 32'hDEAD_BEEF;
        bus.src_b = 32'd0;
        step();
        bus.op = 3'd4;
        bus.src_a = 32'h55;
        for (int k = 1; k <= 35; k++) begin
            if (k > 1) step();
            check($sformatf("hold_busy k%0d", k), bus.busy, k <= 33);
            check($sformatf("hold_hi_wen k%0d", k), bus.hi_wen, k == 33 || k == 35);
            check($sformatf("hold_lo_wen k%0d", k), bus.lo_wen, k == 33);
            if (k == 33) check("divz_hi", bus.hi_wdata, 32'hDEAD_BEEF);
            if (k == 33) check("divz_lo", bus.lo_wdata, 32'hFFFF_FFFF);
            if (k == 35) check("hold_mthi_data", bus.hi_wdata, 32'h55);
        end
        bus.op_valid = 1'b0;
        hi_m = 32'h55;
        lo_m = 32'hFFFF_FFFF;
        step();
        check("hold_after_wen", {bus.hi_wen, bus.lo_wen}, 0);

        // flush in the middle of a divide, then an immediate second divide
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = 3'd2;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        step();
        bus.op_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) step();
            check($sformatf("flush_busy k%0d", k), bus.busy, k <= 10);
            check($sformatf("flush_wen k%0d", k), {bus.hi_wen, bus.lo_wen}, 0);
            if (k == 10) bus.flush = 1'b1;
        end
        bus.flush = 1'b0;
        run(3'd2, 32'hFFFF_FC18, 32'd7);

        // flush blocks acceptance in IDLE
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = 3'd4;
        bus.src_a = 32'hAA;
        bus.flush = 1'b1;
        step();
        bus.op_valid = 1'b0;
        bus.flush = 1'b0;
        check("idle_flush_busy", bus.busy, 0);
        check("idle_flush_wen", bus.hi_wen, 0);

        // reset mid-multiply aborts without a write
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = 3'd0;
        bus.src_a = 32'd7;
        bus.src_b = 32'd9;
        step();
        bus.op_valid = 1'b0;
        check("rstmid_busy_before", bus.busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_wdata", bus.hi_wdata, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("rstmid_wen k%0d", k), {bus.hi_wen, bus.lo_wen}, 0);
        end

`ifdef HILO_MADD_EN
        run(3'd4, 32'd0, 32'd0);
        run(3'd5, 32'd10, 32'd0);
        run(3'd6, 32'd3, 32'd4);
        run(3'd7, 32'd1, 32'd23);
`else
        run(3'd6, 32'd3, 32'd4);
        run(3'd7, 32'd1, 32'd23);
`endif

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 4) == 0) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            run(rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
